// File: rtl/bakraid_eeprom.sv
// ---------------------------------------------------------------------------
// bakraid_eeprom -- 93C66-style serial EEPROM (x16 organisation) emulation.
//
// The CPU side talks the Microwire protocol on SCLK/SCS/SDI/SDO. These pins
// are sampled into the CLK domain, so the serial clock must be slow compared
// to CLK. A separate host port lets a loader preload the array and lets
// NVRAM-save logic read it back without touching the serial side.
//
// Ports:
//   CLK        system clock
//   RESET      asynchronous active-high reset (array contents are kept)
//   SCLK       serial clock from the CPU
//   SCS        chip select, active-high
//   SDI        serial data from the CPU
//   SDO        serial data / ready-busy status to the CPU (1 when SCS=0)
//   HOST_ADDR  host word address
//   HOST_DIN   host write data
//   HOST_WE    host write strobe
//   HOST_DOUT  registered array[HOST_ADDR], one CLK of latency
// ---------------------------------------------------------------------------
module bakraid_eeprom #(
  parameter int AW          = 8,
  parameter int DW          = 16,
  parameter int BUSY_CYCLES = 4800
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          SCLK,
  input  logic          SCS,
  input  logic          SDI,
  output logic          SDO,
  input  logic [AW-1:0] HOST_ADDR,
  input  logic [DW-1:0] HOST_DIN,
  input  logic          HOST_WE,
  output logic [DW-1:0] HOST_DOUT
);

  localparam int WORDS    = 1 << AW;
  // Bulk operations touch one word per CLK, so they may need longer than
  // the nominal program time.
  localparam int BULK_LEN = (BUSY_CYCLES > WORDS) ? BUSY_CYCLES : WORDS;
  localparam int BCW      = $clog2(BULK_LEN + 1);
  // Bit counter must reach DW+1 so that over-long writes can be rejected.
  localparam int CW       = $clog2(((AW > DW) ? AW : DW) + 2);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_OPCODE = 3'd1;
  localparam logic [2:0] S_ADDR   = 3'd2;
  localparam logic [2:0] S_DUMMY  = 3'd3;
  localparam logic [2:0] S_READ   = 3'd4;
  localparam logic [2:0] S_WDATA  = 3'd5;
  localparam logic [2:0] S_BUSY   = 3'd6;
  localparam logic [2:0] S_READY  = 3'd7;

  logic [DW-1:0] mem [WORDS];

  // Synchroniser chains; sclk_q[2] is the previous synchronised value.
  logic [2:0]     sclk_q;
  logic [1:0]     scs_q;
  logic [1:0]     sdi_q;

  logic [2:0]     state_q, state_d;
  logic [1:0]     op_q, op_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [DW-1:0]  data_q, data_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [BCW-1:0] busy_q, busy_d;
  logic [AW-1:0]  widx_q, widx_d;
  logic           wen_q, wen_d;
  logic           bulk_q, bulk_d;
  logic           pend_q, pend_d;
  logic           rdbit_q, rdbit_d;
  logic           sdo_q, sdo_d;
  logic [DW-1:0]  hdout_q;

  logic           scs_s;
  logic           sdi_s;
  logic           rise;
  logic [AW-1:0]  next_addr;
  logic [AW-1:0]  addr_inc;
  logic [DW-1:0]  rd_word;
  logic [DW-1:0]  rd_next;
  logic           sw_en;
  logic [AW-1:0]  sw_addr;
  logic [DW-1:0]  sw_data;

  assign scs_s     = scs_q[1];
  assign sdi_s     = sdi_q[1];
  // A deselected chip ignores edges, so a simultaneous SCS fall wins.
  assign rise      = scs_s & sclk_q[1] & ~sclk_q[2];
  assign next_addr = {addr_q[AW-2:0], sdi_s};
  assign addr_inc  = addr_q + 1'b1;
  assign rd_word   = mem[addr_q];
  assign rd_next   = mem[addr_inc];

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    widx_d  = widx_q;
    wen_d   = wen_q;
    bulk_d  = bulk_q;
    pend_d  = pend_q;
    rdbit_d = rdbit_q;
    sw_en   = 1'b0;
    sw_addr = addr_q;
    sw_data = data_q;

    case (state_q)
      S_IDLE, S_READY: begin
        if (!scs_s) begin
          state_d = S_IDLE;
        end else if (rise && sdi_s) begin
          state_d = S_OPCODE;
          cnt_d   = '0;
        end
      end

      S_OPCODE: begin
        if (!scs_s) begin
          state_d = S_IDLE;
        end else if (rise) begin
          op_d = {op_q[0], sdi_s};
          if (cnt_q == CW'(1)) begin
            cnt_d   = '0;
            state_d = S_ADDR;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      S_ADDR: begin
        if (!scs_s) begin
          state_d = S_IDLE;
        end else if (rise) begin
          addr_d = next_addr;
          if (cnt_q == CW'(AW - 1)) begin
            cnt_d   = '0;
            state_d = S_IDLE;
            case (op_q)
              2'b10: begin
                state_d = S_DUMMY;
                rdbit_d = 1'b0;
              end
              2'b01: begin
                state_d = S_WDATA;
                bulk_d  = 1'b0;
              end
              2'b11: begin
                if (wen_q) begin
                  data_d  = '1;
                  bulk_d  = 1'b0;
                  pend_d  = 1'b1;
                  busy_d  = BCW'(BUSY_CYCLES - 1);
                  state_d = S_BUSY;
                end
              end
              default: begin
                case (next_addr[AW-1:AW-2])
                  2'b11: wen_d = 1'b1;
                  2'b00: wen_d = 1'b0;
                  2'b10: begin
                    if (wen_q) begin
                      data_d  = '1;
                      bulk_d  = 1'b1;
                      pend_d  = 1'b1;
                      widx_d  = '0;
                      busy_d  = BCW'(BULK_LEN - 1);
                      state_d = S_BUSY;
                    end
                  end
                  default: begin
                    state_d = S_WDATA;
                    bulk_d  = 1'b1;
                  end
                endcase
              end
            endcase
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      S_DUMMY: begin
        if (!scs_s) begin
          state_d = S_IDLE;
        end else if (rise) begin
          rdbit_d = rd_word[DW-1];
          data_d  = {rd_word[DW-2:0], 1'b0};
          cnt_d   = '0;
          state_d = S_READ;
        end
      end

      S_READ: begin
        if (!scs_s) begin
          state_d = S_IDLE;
        end else if (rise) begin
          if (cnt_q == CW'(DW - 1)) begin
            // Sequential read rolls straight into the next word.
            addr_d  = addr_inc;
            rdbit_d = rd_next[DW-1];
            data_d  = {rd_next[DW-2:0], 1'b0};
            cnt_d   = '0;
          end else begin
            rdbit_d = data_q[DW-1];
            data_d  = {data_q[DW-2:0], 1'b0};
            cnt_d   = cnt_q + 1'b1;
          end
        end
      end

      S_WDATA: begin
        if (!scs_s) begin
          state_d = S_IDLE;
          if (cnt_q == CW'(DW) && wen_q) begin
            pend_d  = 1'b1;
            widx_d  = '0;
            busy_d  = bulk_q ? BCW'(BULK_LEN - 1) : BCW'(BUSY_CYCLES - 1);
            state_d = S_BUSY;
          end
        end else if (rise) begin
          data_d = {data_q[DW-2:0], sdi_s};
          if (cnt_q != CW'(DW + 1)) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      S_BUSY: begin
        if (pend_q) begin
          sw_en   = 1'b1;
          sw_addr = bulk_q ? widx_q : addr_q;
          widx_d  = widx_q + 1'b1;
          if (!bulk_q || widx_q == '1) begin
            pend_d = 1'b0;
          end
        end
        if (busy_q == '0) begin
          state_d = S_READY;
        end else begin
          busy_d = busy_q - 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // SDO follows the next state so it settles in the same CLK as the FSM.
  always_comb begin
    sdo_d = 1'b1;
    if (scs_s) begin
      case (state_d)
        S_BUSY:          sdo_d = 1'b0;
        S_DUMMY, S_READ: sdo_d = rdbit_d;
        default:         sdo_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sclk_q  <= '0;
      scs_q   <= '0;
      sdi_q   <= '0;
      state_q <= S_IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= '0;
      widx_q  <= '0;
      wen_q   <= 1'b0;
      bulk_q  <= 1'b0;
      pend_q  <= 1'b0;
      rdbit_q <= 1'b0;
      sdo_q   <= 1'b1;
    end else begin
      sclk_q  <= {sclk_q[1:0], SCLK};
      scs_q   <= {scs_q[0], SCS};
      sdi_q   <= {sdi_q[0], SDI};
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      widx_q  <= widx_d;
      wen_q   <= wen_d;
      bulk_q  <= bulk_d;
      pend_q  <= pend_d;
      rdbit_q <= rdbit_d;
      sdo_q   <= sdo_d;
    end
  end

  // Array has no reset. The host write is issued last so it wins a collision.
  always_ff @(posedge CLK) begin
    if (sw_en) begin
      mem[sw_addr] <= sw_data;
    end
    if (HOST_WE) begin
      mem[HOST_ADDR] <= HOST_DIN;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      hdout_q <= '0;
    end else begin
      hdout_q <= mem[HOST_ADDR];
    end
  end

  assign SDO       = sdo_q;
  assign HOST_DOUT = hdout_q;

endmodule

// File: doc/bakraid_eeprom.md
BAKRAID_EEPROM -- requirements
Module: bakraid_eeprom

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- AW, 8, word address width (93C66 in x16 organisation).
- DW, 16, data word width.
- BUSY_CYCLES, 4800, CLK cycles a program or erase operation stays busy.

REQ-002 The block SHALL have these ports (name, direction, width, meaning). Clock and reset: one clock; reset is asynchronous and active-high.
- CLK, in, 1, 48 MHz system clock.
- RESET, in, 1, asynchronous active-high reset.
- SCLK, in, 1, serial clock from CPU side.
- SCS, in, 1, chip select, active-high.
- SDI, in, 1, serial data from CPU.
- SDO, out, 1, serial data or ready/busy to CPU.
- HOST_ADDR, in, AW, loader/NVRAM-save word address.
- HOST_DIN, in, DW, loader write data.
- HOST_WE, in, 1, loader write strobe.
- HOST_DOUT, out, DW, loader read data.

Function
REQ-003 SCLK, SCS and SDI SHALL pass through 2-flop synchronisers; a SCLK rising edge is the synchronised 0->1 transition.
- SDI SHALL be sampled on that detected edge.
- SDO SHALL update within 4 CLK cycles of the SCLK pin rising edge.

REQ-004 Storage SHALL be a 2^AW x DW array. Contents are not cleared by RESET.

REQ-005 The host port SHALL be independent of the serial side.
- HOST_DOUT is the registered array[HOST_ADDR], 1 CLK latency.
- HOST_WE writes HOST_DIN on the same edge.
- A host write SHALL take priority over a same-cycle serial write to the same address.

REQ-006 The FSM states SHALL be IDLE, OPCODE, ADDR, DUMMY, READ, WDATA, BUSY, READY.

REQ-007 IDLE: a rising edge with SCS=1 and SDI=1 (start bit) SHALL go to OPCODE. Rising edges with SDI=0 SHALL be ignored (leading zeros).

REQ-008 OPCODE SHALL shift 2 bits, then go to ADDR, which shifts AW bits MSB first.

REQ-009 After the last address bit the block SHALL decode:
- 10 READ: go to DUMMY.
- 01 WRITE: go to WDATA.
- 11 ERASE: execute.
- 00 with addr[AW-1:AW-2] = 11 EWEN, 00 EWDS, 10 ERAL, 01 WRAL (WRAL goes to WDATA).

REQ-010 DUMMY SHALL drive SDO=0 immediately after the last address bit. Then, on each following rising edge, SDO SHALL present the next data bit, MSB first, for DW bits.

REQ-011 After the LSB of a READ, the address SHALL auto-increment (wrapping at 2^AW-1 -> 0) and streaming SHALL continue while SCS stays high.

REQ-012 WDATA SHALL shift DW bits MSB first. The operation commits on the SCS falling edge, and only if exactly DW bits were received.

REQ-013 Commit rules:
- WRITE stores the data at addr; ERASE stores all-ones at addr.
- ERAL stores all-ones at every word; WRAL stores the data at every word.
- All of these execute only if the write-enable latch WEN=1; otherwise they are a no-op with no BUSY.

REQ-014 EWEN SHALL set WEN and EWDS SHALL clear WEN, both taking effect at the last address bit.

REQ-015 A committed program or erase SHALL enter BUSY for BUSY_CYCLES CLK cycles, then go to READY.
- ERAL/WRAL SHALL iterate one word per CLK, and BUSY SHALL last at least 2^AW cycles.

REQ-016 While in BUSY or READY with SCS=1, SDO SHALL be 0 in BUSY and 1 in READY.
- A start bit is ignored while BUSY.
- A start bit in READY begins a new command (goes to OPCODE).

REQ-017 SCS low SHALL abort any shift state (OPCODE, ADDR, DUMMY, READ, WDATA) back to IDLE.
- BUSY SHALL continue to completion regardless of SCS.
- SDO SHALL be 1 whenever SCS=0 (open-drain idle).

REQ-018 Simultaneous SCS fall and SCLK rise SHALL be resolved as SCS fall first; that edge is not sampled.

Reset
REQ-019 RESET SHALL force:
- state = IDLE, WEN=0, SDO=1, HOST_DOUT=0;
- shift registers, bit counters and busy counter = 0.

REQ-020 RESET asserted mid-BUSY SHALL abandon the remainder of ERAL/WRAL. Words already written SHALL remain.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Host writes 0x1234 to addr 0x05; serial READ addr 0x05 -> SDO bits 0, then 0x1234 MSB first.
- After RESET, WRITE addr 0x10 data 0xBEEF, then READ -> old value returned, no BUSY (WEN=0).
- EWEN, WRITE 0x10=0xBEEF, SCS low then high -> SDO=0 for BUSY_CYCLES, then 1; READ returns 0xBEEF.
- READ at addr 0xFF continued for 32 data bits -> array[0xFF] then array[0x00].
- WRITE aborted after 9 data bits by SCS low -> no write, state IDLE, SDO=1.
- EWEN, ERAL -> every HOST_DOUT reads 0xFFFF. RESET during WRAL 0x00AA at word 0x40 -> words 0x00-0x3F = 0x00AA, words 0x41 and above unchanged.
